// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and defaults for the APB master front-end.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_WIDTH_DEF = 16;

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after the pointer.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_eligible,
  input  logic [PTR_W-1:0] pointer,
  output logic [NREQ-1:0]  pick,
  output logic             any_req
);

  logic [PTR_W:0] pos_s;
  logic           found_s;

  // Scan from the pointer upward, wrapping NREQ-1 -> 0; first hit wins
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    pos_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, pointer} + (PTR_W+1)'(k);
      if (pos_s >= (PTR_W+1)'(NREQ)) begin
        pos_s = pos_s - (PTR_W+1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req_eligible[pos_s[PTR_W-1:0]]) begin
        pick[pos_s[PTR_W-1:0]] = 1'b1;
        found_s                = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any_req = found_s;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master that shares one bus among NREQ requesters with round-robin
// arbitration and an ACCESS-phase timeout.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = APB_WIDTH_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ*WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WIDTH-1:0]      rdata,
  output logic                  pselect,
  output logic                  penable,
  output logic                  pwrite,
  output logic [WIDTH-1:0]      paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic                  pready,
  input  logic [WIDTH-1:0]      prdata
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  apb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic             err_q, err_d, psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [WIDTH-1:0] rdata_q, rdata_d, paddr_q, paddr_d, pwdata_q, pwdata_d;

  logic [NREQ-1:0]  eligible_s, pick_s;
  logic             any_req_s, sel_write_s;
  logic [PTR_W-1:0] pick_idx_s, next_ptr_s;
  logic [WIDTH-1:0] sel_addr_s, sel_wdata_s;

  // The owner finishing this cycle must not be re-picked on the same edge
  assign eligible_s = req & ~done_q;
  assign next_ptr_s = (idx_q == PTR_W'(NREQ-1)) ? '0 : idx_q + PTR_W'(1);

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .req_eligible (eligible_s),
    .pointer      (ptr_q),
    .pick         (pick_s),
    .any_req      (any_req_s)
  );

  // AND-OR mux of the winner's command and index (pick_s is one-hot)
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_write_s = 1'b0;
    pick_idx_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s  = sel_addr_s  | (req_addr[i*WIDTH +: WIDTH]  & {WIDTH{pick_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*WIDTH +: WIDTH] & {WIDTH{pick_s[i]}});
      sel_write_s = sel_write_s | (req_write[i] & pick_s[i]);
      pick_idx_s  = pick_idx_s  | (pick_s[i] ? PTR_W'(i) : '0);
    end
  end

  // Next-state and registered-output logic of the APB sequencer
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          paddr_d  = sel_addr_s;
          pwdata_d = sel_wdata_s;
          pwrite_d = sel_write_s;
          gnt_d    = pick_s;
          idx_d    = pick_idx_s;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          state_d  = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done_d  = gnt_q;
          err_d   = 1'b0;
          rdata_d = pwrite_q ? rdata_q : prdata;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          gnt_d   = '0;
          ptr_d   = next_ptr_s;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          rdata_d = '0;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          gnt_d   = '0;
          ptr_d   = next_ptr_s;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d  = 1'b0;
        pen_d   = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign pselect = psel_q;
  assign penable = pen_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a completion scoreboard.
module tb_apb_master_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 16;

  logic                  pclk;
  logic                  preset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_write;
  logic [NREQ*WIDTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [WIDTH-1:0]      rdata;
  logic                  pselect;
  logic                  penable;
  logic                  pwrite;
  logic [WIDTH-1:0]      paddr;
  logic [WIDTH-1:0]      pwdata;
  logic                  pready;
  logic [WIDTH-1:0]      prdata;

  logic                  tie_mode;
  logic                  pready_man;

  typedef struct {
    int              idx;
    bit              is_write;
    bit              err;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] model_rdata;
  int               tests;
  int               fails;

  apb_master_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .pselect   (pselect),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  assign pready = tie_mode ? penable : pready_man;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input int idx, input bit is_write, input bit e, input logic [WIDTH-1:0] d);
    exp_t x;
    x.idx = idx; x.is_write = is_write; x.err = e; x.data = d;
    sb_q.push_back(x);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    req_write[i]              = wr;
    req_addr[i*WIDTH +: WIDTH]  = a;
    req_wdata[i*WIDTH +: WIDTH] = d;
    req[i]                    = 1'b1;
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge pclk) begin
    if (done !== '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        exp_t x;
        logic [WIDTH-1:0] want;
        x = sb_q.pop_front();
        check("sb_done", 32'(done), 32'(1 << x.idx));
        check("sb_err", 32'(err), 32'(x.err));
        if (x.err) want = '0;
        else if (x.is_write) want = model_rdata;
        else want = x.data;
        check("sb_rdata", 32'(rdata), 32'(want));
        model_rdata = want;
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    model_rdata = '0;
    preset_n = 1'b0;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    tie_mode = 1'b1; pready_man = 1'b0; prdata = '0;
    tick(); tick();
    check("rst_pselect", 32'(pselect), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done_err", 32'({done, err, pwrite}), 32'h0);
    check("rst_buses", 32'({paddr, pwdata}), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    preset_n = 1'b1;
    tick();

    // 1. single zero-wait write from requester 0
    set_req(0, 1'b1, 16'h0010, 16'hBEEF);
    push(0, 1'b1, 1'b0, 16'h0000);
    tick();
    check("t1_c1_psel_pen", 32'({pselect, penable}), 32'h2);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_paddr", 32'(paddr), 32'h0010);
    check("t1_pwdata_pwrite", 32'({pwdata, pwrite}), 32'({16'hBEEF, 1'b1}));
    tick();
    check("t1_c2_psel_pen", 32'({pselect, penable}), 32'h3);
    tick();
    check("t1_c3_done", 32'(done), 32'h1);
    check("t1_c3_err_psel", 32'({err, pselect, penable}), 32'h0);
    req[0] = 1'b0;
    tick();
    check("t1_c4_idle", 32'({done, pselect}), 32'h0);

    // 2. read on requester 2 with three wait states
    tie_mode = 1'b0; pready_man = 1'b0;
    set_req(2, 1'b0, 16'h0044, 16'h0000);
    push(2, 1'b0, 1'b0, 16'h1234);
    tick();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_paddr_pwrite", 32'({paddr, pwrite}), 32'({16'h0044, 1'b0}));
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_penable_held", 32'({penable, done}), 32'h10);
      if (k == 3) begin
        pready_man = 1'b1; prdata = 16'h1234;
      end
      tick();
    end
    check("t2_done", 32'(done), 32'h4);
    check("t2_rdata", 32'(rdata), 32'h1234);
    check("t2_bus_released", 32'({pselect, penable}), 32'h0);
    req[2] = 1'b0; pready_man = 1'b0; prdata = 16'hDEAD;
    tick();

    // 4. timeout on requester 1, slave never ready
    set_req(1, 1'b0, 16'h0080, 16'h0000);
    push(1, 1'b0, 1'b1, 16'h0000);
    tick();
    check("t4_gnt", 32'(gnt), 32'h2);
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      check("t4_access_wait", 32'({penable, done}), 32'h10);
      tick();
    end
    check("t4_done", 32'(done), 32'h2);
    check("t4_err", 32'(err), 32'h1);
    check("t4_rdata_zero", 32'(rdata), 32'h0);
    check("t4_pselect", 32'({pselect, penable}), 32'h0);
    req[1] = 1'b0;
    tick();
    check("t4_pulse_once", 32'({done, err}), 32'h0);

    // 6. req[1] dropped during SETUP, address changed mid-transfer
    tie_mode = 1'b1;
    set_req(1, 1'b1, 16'h0200, 16'h5555);
    push(1, 1'b1, 1'b0, 16'h0000);
    tick();
    req[1] = 1'b0;
    req_addr[1*WIDTH +: WIDTH]  = 16'h0FFF;
    req_wdata[1*WIDTH +: WIDTH] = 16'h0AAA;
    check("t6_setup", 32'({pselect, penable}), 32'h2);
    tick();
    check("t6_paddr_stable", 32'(paddr), 32'h0200);
    check("t6_pwdata_stable", 32'(pwdata), 32'h5555);
    tick();
    check("t6_done", 32'(done), 32'h2);
    tick();
    check("t6_no_restart", 32'({pselect, done}), 32'h0);

    // 5. asynchronous reset in the middle of ACCESS
    tie_mode = 1'b0; pready_man = 1'b0;
    set_req(3, 1'b0, 16'h0300, 16'h0000);
    tick(); tick(); tick();
    check("t5_in_access", 32'({pselect, penable, gnt}), 32'h38);
    preset_n = 1'b0;
    #1;
    check("t5_async_release", 32'({pselect, penable, gnt}), 32'h0);
    req = '0;
    model_rdata = '0;
    tick();
    check("t5_no_done", 32'({done, err}), 32'h0);
    preset_n = 1'b1;
    tick();
    check("t5_idle_after", 32'({pselect, done}), 32'h0);

    // 3. all four held high: grants 0,1,2,3,0 with one idle cycle between
    tie_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, 16'(16'h0100 + i), 16'(16'hA000 + i));
    end
    push(0, 1'b1, 1'b0, 16'h0); push(1, 1'b1, 1'b0, 16'h0);
    push(2, 1'b1, 1'b0, 16'h0); push(3, 1'b1, 1'b0, 16'h0);
    push(0, 1'b1, 1'b0, 16'h0);
    tick();
    for (int t = 0; t < 5; t++) begin
      int w;
      w = t % NREQ;
      check("t3_pselect", 32'(pselect), 32'h1);
      check("t3_gnt", 32'(gnt), 32'(1 << w));
      check("t3_paddr", 32'(paddr), 32'(16'h0100 + w));
      tick();
      check("t3_penable", 32'(penable), 32'h1);
      tick();
      check("t3_gap", 32'({pselect, done}), 32'(1 << w));
      if (t == 4) req = '0;
      tick();
    end
    check("t3_quiet", 32'({pselect, gnt}), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
